// File: rtl/keycode_event_scheduler.sv
// Turns the raw HID keycode into rate-limited per-player move/bomb commands on a valid/ready stream.
// Optional build macro KEYCODE_SCHED_STATS_EN adds the dropped_cnt overwrite counter output.
module keycode_event_scheduler #(
    parameter int REPEAT_CYCLES = 5000000,
    parameter int CNT_W         = 23
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic       cmd_player,
    output logic [2:0] cmd_action,
`ifdef KEYCODE_SCHED_STATS_EN
    output logic [7:0] dropped_cnt,
`endif
    output logic [1:0] key_active
);

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [2:0]       ACT_BOMB = 3'd4;

    typedef enum logic {IDLE, HELD} trk_state_t;

    logic [7:0]       kc_q;
    trk_state_t       state_q    [2];
    trk_state_t       state_d    [2];
    logic [2:0]       held_act_q [2];
    logic [2:0]       held_act_d [2];
    logic [CNT_W-1:0] cnt_q      [2];
    logic [CNT_W-1:0] cnt_d      [2];
    logic [2:0]       pact_q     [2];
    logic [2:0]       pact_d     [2];
    logic [1:0]       pend_q, pend_d;
    logic [1:0]       key_hit, ev, take;
    logic [2:0]       key_act;
    logic             vld_q, player_q, last_q;
    logic [2:0]       action_q;
    logic             load, gnt_any, gnt_p;

    always_comb begin
        key_hit = 2'b00;
        key_act = 3'd0;
        case (kc_q)
            8'h1A: begin key_hit = 2'b01; key_act = 3'd0; end
            8'h16: begin key_hit = 2'b01; key_act = 3'd1; end
            8'h04: begin key_hit = 2'b01; key_act = 3'd2; end
            8'h07: begin key_hit = 2'b01; key_act = 3'd3; end
            8'h2C: begin key_hit = 2'b01; key_act = 3'd4; end
            8'h52: begin key_hit = 2'b10; key_act = 3'd0; end
            8'h51: begin key_hit = 2'b10; key_act = 3'd1; end
            8'h50: begin key_hit = 2'b10; key_act = 3'd2; end
            8'h4F: begin key_hit = 2'b10; key_act = 3'd3; end
            8'h28: begin key_hit = 2'b10; key_act = 3'd4; end
            default: ;
        endcase
    end

    // Per-player hold tracker: a change of key within the same player is a fresh press.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            ev[p]         = 1'b0;
            state_d[p]    = state_q[p];
            held_act_d[p] = held_act_q[p];
            cnt_d[p]      = cnt_q[p];
            if (!key_hit[p]) begin
                state_d[p] = IDLE;
                cnt_d[p]   = '0;
            end else if (state_q[p] == IDLE || key_act != held_act_q[p]) begin
                ev[p]         = 1'b1;
                state_d[p]    = HELD;
                held_act_d[p] = key_act;
                cnt_d[p]      = RELOAD;
            end else if (cnt_q[p] != '0) begin
                cnt_d[p] = cnt_q[p] - CNT_W'(1);
            end else if (held_act_q[p] != ACT_BOMB) begin
                ev[p]    = 1'b1;
                cnt_d[p] = RELOAD;
            end
        end
    end

    // Round-robin grant; a fresh event on the granted player's slot beats the clear.
    always_comb begin
        load    = ~vld_q | cmd_ready;
        gnt_any = |pend_q;
        gnt_p   = (pend_q == 2'b11) ? ~last_q : pend_q[1];
        take    = (load && gnt_any) ? (gnt_p ? 2'b10 : 2'b01) : 2'b00;
        for (int p = 0; p < 2; p++) begin
            pend_d[p] = ev[p] | (pend_q[p] & ~take[p]);
            pact_d[p] = ev[p] ? key_act : pact_q[p];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kc_q <= '0;
            for (int p = 0; p < 2; p++) begin
                state_q[p]    <= IDLE;
                held_act_q[p] <= '0;
                cnt_q[p]      <= '0;
                pact_q[p]     <= '0;
            end
            pend_q   <= '0;
            vld_q    <= 1'b0;
            player_q <= 1'b0;
            action_q <= '0;
            last_q   <= 1'b1;
        end else begin
            kc_q <= keycode;
            for (int p = 0; p < 2; p++) begin
                state_q[p]    <= state_d[p];
                held_act_q[p] <= held_act_d[p];
                cnt_q[p]      <= cnt_d[p];
                pact_q[p]     <= pact_d[p];
            end
            pend_q <= pend_d;
            if (load) begin
                vld_q <= gnt_any;
                if (gnt_any) begin
                    player_q <= gnt_p;
                    action_q <= pact_q[gnt_p];
                    last_q   <= gnt_p;
                end
            end
        end
    end

`ifdef KEYCODE_SCHED_STATS_EN
    logic [7:0] drop_q;
    logic       drop;

    assign drop = |(ev & pend_q & ~take);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_q <= '0;
        else if (drop && drop_q != 8'hFF)
            drop_q <= drop_q + 8'd1;
    end

    assign dropped_cnt = drop_q;
`endif

    assign cmd_valid  = vld_q;
    assign cmd_player = player_q;
    assign cmd_action = action_q;
    assign key_active = {state_q[1] == HELD, state_q[0] == HELD};

endmodule

// File: tb/tb_keycode_event_scheduler.sv
// Bench for keycode_event_scheduler: directed scenarios plus random key/ready traffic against a hold-age reference model.
module tb_keycode_event_scheduler;

    localparam int R = 8;
    localparam logic [7:0] KC [10] = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C,
                                       8'h52, 8'h51, 8'h50, 8'h4F, 8'h28};

    logic       clk;
    logic       reset_n;
    logic [7:0] keycode;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_player;
    logic [2:0] cmd_action;
    logic [1:0] key_active;
`ifdef KEYCODE_SCHED_STATS_EN
    logic [7:0] dropped_cnt;
`endif

    int tests = 0;
    int fails = 0;

    keycode_event_scheduler #(.REPEAT_CYCLES(R), .CNT_W(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keycode    (keycode),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_player (cmd_player),
        .cmd_action (cmd_action),
`ifdef KEYCODE_SCHED_STATS_EN
        .dropped_cnt(dropped_cnt),
`endif
        .key_active (key_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what each player is holding, how long, and the one-deep mailboxes.
    logic [7:0] m_kc;
    bit         m_held [2];
    int         m_key  [2];
    int         m_age  [2];
    bit         m_pend [2];
    int         m_pact [2];
    bit         m_vld;
    int         m_player, m_action, m_last, m_drop;

    task automatic model_reset();
        m_kc = 8'h00;
        for (int p = 0; p < 2; p++) begin
            m_held[p] = 0; m_key[p] = 0; m_age[p] = 0; m_pend[p] = 0; m_pact[p] = 0;
        end
        m_vld = 0; m_player = 0; m_action = 0; m_last = 1; m_drop = 0;
    endtask

    task automatic model_edge();
        bit load;
        int g, hp, ha;
        bit ev [2];
        load = !m_vld || cmd_ready;
        g = -1;
        if (m_pend[0] && m_pend[1]) g = 1 - m_last;
        else if (m_pend[0]) g = 0;
        else if (m_pend[1]) g = 1;
        hp = -1; ha = 0;
        for (int i = 0; i < 10; i++)
            if (m_kc == KC[i]) begin hp = i / 5; ha = i % 5; end
        for (int p = 0; p < 2; p++) begin
            ev[p] = 0;
            if (hp == p) begin
                if (!m_held[p] || m_key[p] != ha) begin
                    m_held[p] = 1; m_key[p] = ha; m_age[p] = 0; ev[p] = 1;
                end else begin
                    m_age[p]++;
                    if (ha != 4 && m_age[p] % R == 0) ev[p] = 1;
                end
            end else begin
                m_held[p] = 0; m_age[p] = 0;
            end
        end
        if (load) begin
            if (g >= 0) begin
                m_vld = 1; m_player = g; m_action = m_pact[g]; m_last = g;
            end else begin
                m_vld = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (ev[p]) begin
                if (m_pend[p] && !(load && g == p) && m_drop < 255) m_drop++;
                m_pend[p] = 1; m_pact[p] = ha;
            end else if (load && g == p) begin
                m_pend[p] = 0;
            end
        end
        m_kc = keycode;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("valid", 32'(cmd_valid), 32'(m_vld));
        if (m_vld) begin
            chk("player", 32'(cmd_player), 32'(m_player));
            chk("action", 32'(cmd_action), 32'(m_action));
        end
        chk("active", 32'(key_active), {30'd0, m_held[1], m_held[0]});
`ifdef KEYCODE_SCHED_STATS_EN
        chk("dropped", 32'(dropped_cnt), 32'(m_drop));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        keycode = 8'h00;
        cmd_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    int nvld, first, seg_len;
    logic [2:0] bomb_act;

    initial begin
        reset_n = 1'b0; keycode = 8'h00; cmd_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_valid",  32'(cmd_valid),  32'd0);
        chk("rst_player", 32'(cmd_player), 32'd0);
        chk("rst_action", 32'(cmd_action), 32'd0);
        chk("rst_active", 32'(key_active), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // W held: first command 3 edges after the change, then one per R cycles.
        keycode = 8'h1A; nvld = 0; first = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (cmd_valid === 1'b1) begin
                nvld++;
                if (first == 0) first = i;
            end
        end
        chk("w_first", 32'(first), 32'd3);
        chk("w_count", 32'(nvld), 32'd3);
        chk("w_active", 32'(key_active), 32'b01);
        idle(4);

        // Space held: exactly one bomb.
        keycode = 8'h2C; nvld = 0; bomb_act = 3'd7;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cmd_valid === 1'b1) begin nvld++; bomb_act = cmd_action; end
        end
        chk("bomb_count", 32'(nvld), 32'd1);
        chk("bomb_action", 32'(bomb_act), 32'd4);
        idle(4);

        // Stalled consumer: P1 right held stable while P2 right waits.
        cmd_ready = 1'b0; keycode = 8'h07;
        tick(); tick(); tick();
        chk("stall_p1_active", 32'(key_active), 32'b01);
        keycode = 8'h4F;
        for (int i = 4; i <= 8; i++) begin
            tick();
            chk("stall_hold", {28'd0, cmd_valid, cmd_player, cmd_action}, {28'd0, 1'b1, 1'b0, 3'd3});
        end
        chk("stall_p2_active", 32'(key_active), 32'b10);
        cmd_ready = 1'b1;
        tick();
        chk("stall_p2_cmd", {28'd0, cmd_valid, cmd_player, cmd_action}, {28'd0, 1'b1, 1'b1, 3'd3});
        idle(12);

        // Both pending after a P1 grant: P2 first.
        cmd_ready = 1'b0; keycode = 8'h1A; tick();
        keycode = 8'h52; tick();
        keycode = 8'h16; tick();
        keycode = 8'h00; tick();
        cmd_ready = 1'b1; tick();
        chk("rr1_first", {28'd0, cmd_valid, cmd_player, cmd_action}, {28'd0, 1'b1, 1'b1, 3'd0});
        tick();
        chk("rr1_second", {28'd0, cmd_valid, cmd_player, cmd_action}, {28'd0, 1'b1, 1'b0, 3'd1});
        idle(3);

        // Both pending after a P2 grant: P1 first.
        cmd_ready = 1'b0; keycode = 8'h52; tick();
        keycode = 8'h1A; tick();
        keycode = 8'h51; tick();
        keycode = 8'h00; tick();
        cmd_ready = 1'b1; tick();
        chk("rr2_first", {28'd0, cmd_valid, cmd_player, cmd_action}, {28'd0, 1'b1, 1'b0, 3'd0});
        tick();
        chk("rr2_second", {28'd0, cmd_valid, cmd_player, cmd_action}, {28'd0, 1'b1, 1'b1, 3'd1});
        idle(3);

        // Coalescing: up loads the slot, down is overwritten by left.
        cmd_ready = 1'b0; keycode = 8'h1A; tick();
        keycode = 8'h16; tick();
        keycode = 8'h04; tick();
        keycode = 8'h00; tick();
`ifdef KEYCODE_SCHED_STATS_EN
        chk("coal_dropped", 32'(dropped_cnt), 32'd1);
`endif
        cmd_ready = 1'b1; tick();
        chk("coal_left", {28'd0, cmd_valid, cmd_player, cmd_action}, {28'd0, 1'b1, 1'b0, 3'd2});
        tick();
        chk("coal_empty", 32'(cmd_valid), 32'd0);
        idle(2);

        // Asynchronous reset with a command and a pending event outstanding.
        cmd_ready = 1'b0; keycode = 8'h1A; tick(); tick();
        keycode = 8'h16; tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid",  32'(cmd_valid),  32'd0);
        chk("arst_active", 32'(key_active), 32'd0);
        model_reset();
        keycode = 8'h00; cmd_ready = 1'b1;
        #2 reset_n = 1'b1;
        nvld = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (cmd_valid !== 1'b0) nvld++;
        end
        chk("arst_quiet", 32'(nvld), 32'd0);

        // Random key sequences and consumer back-pressure.
        for (int seg = 0; seg < 60; seg++) begin
            int r;
            r = $urandom_range(0, 11);
            if (r < 10) keycode = KC[r];
            else if (r == 10) keycode = 8'h00;
            else keycode = 8'($urandom_range(0, 255));
            seg_len = $urandom_range(1, 12);
            for (int j = 0; j < seg_len; j++) begin
                cmd_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keycode_event_scheduler.md
Name: keycode_event_scheduler

Overview:
Converts the raw 8-bit USB HID keycode from the NIOS-written keycode PIO into discrete, rate-limited movement/bomb commands for the two Bomberman players. Tracks the held key per player, generates auto-repeat events, and round-robin arbitrates both players' pending events onto a single valid/ready command stream consumed by the game-state logic.

Parameters:
REPEAT_CYCLES, 5000000, clk cycles between auto-repeat events while a movement key is held (100 ms at 50 MHz); legal range 2..2^CNT_W-1
CNT_W, 23, width of each repeat counter

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
keycode  input  8  current keycode from PIO out_port; 0x00 = no key
cmd_valid  output  1  command available
cmd_ready  input  1  consumer accepts command when high with cmd_valid
cmd_player  output  1  0 = player 1, 1 = player 2
cmd_action  output  3  0 up, 1 down, 2 left, 3 right, 4 bomb
key_active  output  2  bit p high while a recognised key of player p is held

Behaviour:
- Reset: asynchronous on reset_n, clocked by clk; cmd_valid=0, cmd_player=0, cmd_action=0, key_active=0, pending flags clear, counters 0, round-robin priority to player 1.
- Decode (on registered kc_q): P1 W 0x1A up, S 0x16 down, A 0x04 left, D 0x07 right, Space 0x2C bomb; P2 0x52 up, 0x51 down, 0x50 left, 0x4F right, Enter 0x28 bomb. Any other value incl. 0x00 = no key.
- keycode registered into kc_q every clk edge.
- Per-player tracker, states IDLE/HELD:
  - IDLE -> HELD on decoded key for that player: set pending[p], latch action, load counter REPEAT_CYCLES-1.
  - HELD, same key: counter decrements; at 0, movement keys set pending[p] again and reload; bomb never repeats.
  - HELD, different key of same player: treat as new press (pending set immediately, counter reloaded).
  - HELD -> IDLE on unrecognised keycode or other player's key; counter cleared; already-pending event retained.
  - key_active[p] = (state==HELD).
- Pending coalescing: pending[p] is one event deep; a new event while set overwrites the stored action.
- Arbiter: output slot loads when cmd_valid=0 or (cmd_valid & cmd_ready). Only one pending -> grant it. Both pending -> grant player opposite to last grant; update last-grant pointer. Granted pending cleared same edge; simultaneous set for same player wins over clear.
- cmd_player/cmd_action stable while cmd_valid & ~cmd_ready. No pending at load -> cmd_valid=0.
- Latency: keycode change before edge k -> kc_q at k -> pending at k+1 -> cmd_valid after k+2 if slot free.
- Reset mid-operation discards pending and output command with no partial handshake.

Optional Feature:
KEYCODE_SCHED_STATS_EN: adds output dropped_cnt [7:0], incremented each time a pending event is overwritten before grant, saturating at 255, reset to 0. Without macro: port and counter absent; coalescing behaviour unchanged.

Test Plan:
REPEAT_CYCLES=8, cmd_ready=1; keycode 0x1A held 20 cycles -> first cmd (player0, action0) 3 cycles after change, then one every 8 cycles; key_active=01.
keycode 0x2C held 30 cycles -> exactly one cmd (player0, action4), no repeats.
cmd_ready=0, keycode 0x07 for 3 cycles then 0x4F -> P1 right loaded and held stable; after ready=1, P1 right then P2 right issued, key_active 01 -> 10.
Both players pending with last grant P1 -> P2 granted first, then P1; repeat with last grant P2 -> P1 first.
cmd_ready=0, 0x1A then 0x16 then 0x04 -> only one extra P1 event survives (left); with KEYCODE_SCHED_STATS_EN dropped_cnt=1.
reset_n low while cmd_valid=1 with pending -> cmd_valid=0, key_active=0 immediately; after release with keycode 0x00 no commands.
